// File: rtl/ctrl_seq_pkg.sv
// Shared types for the control-step sequencer: FSM states, opcode map,
// IR field positions and the opcode class helper.
package ctrl_seq_pkg;
  localparam int OPC_BITS = 5;
  localparam int REG_BITS = 4;

  localparam int OPC_MSB = 31, OPC_LSB = 27;
  localparam int RA_MSB  = 26, RA_LSB  = 23;
  localparam int RB_MSB  = 22, RB_LSB  = 19;
  localparam int RC_MSB  = 18, RC_LSB  = 15;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_e;
  typedef enum logic [1:0] {CLS_TWO_OP, CLS_MULDIV, CLS_ONE_OP, CLS_ILLEGAL} op_class_e;

  typedef logic [OPC_BITS-1:0] opc_t;

  localparam opc_t OPC_ADD  = 5'b00011;
  localparam opc_t OPC_SUB  = 5'b00100;
  localparam opc_t OPC_AND  = 5'b00101;
  localparam opc_t OPC_OR   = 5'b00110;
  localparam opc_t OPC_SHR  = 5'b00111;
  localparam opc_t OPC_SHRA = 5'b01000;
  localparam opc_t OPC_SHL  = 5'b01001;
  localparam opc_t OPC_ROR  = 5'b01010;
  localparam opc_t OPC_ROL  = 5'b01011;
  localparam opc_t OPC_ADDI = 5'b01100;
  localparam opc_t OPC_ANDI = 5'b01101;
  localparam opc_t OPC_ORI  = 5'b01110;
  localparam opc_t OPC_MUL  = 5'b01111;
  localparam opc_t OPC_DIV  = 5'b10000;
  localparam opc_t OPC_NEG  = 5'b10001;
  localparam opc_t OPC_NOT  = 5'b10010;

  function automatic op_class_e op_class(input opc_t opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA,
      OPC_SHL, OPC_ROR, OPC_ROL, OPC_ADDI, OPC_ANDI, OPC_ORI: return CLS_TWO_OP;
      OPC_MUL, OPC_DIV:                                       return CLS_MULDIV;
      OPC_NEG, OPC_NOT:                                       return CLS_ONE_OP;
      default:                                                return CLS_ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_step_sequencer_if.sv
// Sequencer <-> datapath bundle: start/IR/memory handshake in, step enables out.
interface ctrl_step_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
);
  logic                start, mem_ack;
  logic [DATA_W-1:0]   ir;
  logic                pc_out, pc_increment, mar_in, zlow_in, zhigh_in;
  logic                zlow_out, zhigh_out, pc_in, read, mdr_in;
  logic                mdr_out, ir_in, y_in, lo_in, hi_in;
  logic [NUM_REGS-1:0] rin, rout;
  logic [OPC_W-1:0]    op_code;
  logic                busy, done, illegal, mem_err;

  modport master (
    input  start, ir, mem_ack,
    output pc_out, pc_increment, mar_in, zlow_in, zhigh_in, zlow_out, zhigh_out,
           pc_in, read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in,
           rin, rout, op_code, busy, done, illegal, mem_err
  );
  modport slave (
    output start, ir, mem_ack,
    input  pc_out, pc_increment, mar_in, zlow_in, zhigh_in, zlow_out, zhigh_out,
           pc_in, read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in,
           rin, rout, op_code, busy, done, illegal, mem_err
  );
endinterface

// File: rtl/ctrl_seq_decode.sv
// Combinational decode of the latched instruction fields into class,
// legality and one-hot register selects.
module ctrl_seq_decode import ctrl_seq_pkg::*; #(
  parameter int NUM_REGS = 16
)(
  input  opc_t                opc,
  input  logic [REG_BITS-1:0] ra,
  input  logic [REG_BITS-1:0] rb,
  input  logic [REG_BITS-1:0] rc,
  output op_class_e           cls,
  output logic                legal,
  output logic [NUM_REGS-1:0] ra_oh,
  output logic [NUM_REGS-1:0] rb_oh,
  output logic [NUM_REGS-1:0] rc_oh
);
  logic ra_ok, rb_ok, rc_ok;

  assign cls   = op_class(opc);
  assign ra_ok = 32'(ra) < NUM_REGS;
  assign rb_ok = 32'(rb) < NUM_REGS;
  assign rc_ok = 32'(rc) < NUM_REGS;

  // Rc only matters for classes that read a second operand
  always_comb begin
    legal = 1'b0;
    case (cls)
      CLS_TWO_OP, CLS_MULDIV: legal = ra_ok & rb_ok & rc_ok;
      CLS_ONE_OP:             legal = ra_ok & rb_ok;
      default:                legal = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_oh
    assign ra_oh[i] = (ra == REG_BITS'(i));
    assign rb_oh[i] = (rb == REG_BITS'(i));
    assign rc_oh[i] = (rc == REG_BITS'(i));
  end
endmodule

// File: rtl/ctrl_step_sequencer.sv
// Fetch/execute control-step FSM for the Phase 1 datapath, with a bounded
// memory-read wait in T1 and illegal-instruction detection in T3.
module ctrl_step_sequencer import ctrl_seq_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 15
)(
  input logic                  clk,
  input logic                  clr,
  ctrl_step_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state, nxt;
  logic [CNT_W-1:0]    cnt, cnt_inc;
  logic                timeout, err_q;
  logic [DATA_W-1:0]   ir_w;
  opc_t                opc_q;
  logic [REG_BITS-1:0] ra_q, rb_q, rc_q;
  op_class_e           cls;
  logic                legal;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;

  assign ir_w = bus.ir;
  wire unused_ir = ^ir_w;

  ctrl_seq_decode #(.NUM_REGS(NUM_REGS)) u_dec (
    .opc(opc_q), .ra(ra_q), .rb(rb_q), .rc(rc_q),
    .cls(cls), .legal(legal), .ra_oh(ra_oh), .rb_oh(rb_oh), .rc_oh(rc_oh)
  );

  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else      state <= nxt;

  // Fields are captured on the T2->T3 edge so IR may change once decode starts
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt   <= '0;
      err_q <= 1'b0;
      opc_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      err_q <= timeout;
      if (state == T0)                      cnt <= '0;
      else if (state == T1 && !bus.mem_ack) cnt <= cnt_inc;
      if (state == T2) begin
        opc_q <= ir_w[OPC_MSB:OPC_LSB];
        ra_q  <= ir_w[RA_MSB:RA_LSB];
        rb_q  <= ir_w[RB_MSB:RB_LSB];
        rc_q  <= ir_w[RC_MSB:RC_LSB];
      end
    end

  always_comb begin
    nxt              = state;
    timeout          = 1'b0;
    cnt_inc          = cnt + 1'b1;
    bus.pc_out       = 1'b0;
    bus.pc_increment = 1'b0;
    bus.mar_in       = 1'b0;
    bus.zlow_in      = 1'b0;
    bus.zhigh_in     = 1'b0;
    bus.zlow_out     = 1'b0;
    bus.zhigh_out    = 1'b0;
    bus.pc_in        = 1'b0;
    bus.read         = 1'b0;
    bus.mdr_in       = 1'b0;
    bus.mdr_out      = 1'b0;
    bus.ir_in        = 1'b0;
    bus.y_in         = 1'b0;
    bus.lo_in        = 1'b0;
    bus.hi_in        = 1'b0;
    bus.rin          = '0;
    bus.rout         = '0;
    bus.op_code      = '0;
    bus.busy         = (state != IDLE);
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;
    bus.mem_err      = err_q;
    case (state)
      IDLE: if (bus.start) nxt = T0;
      T0: begin
        bus.pc_out = 1'b1; bus.pc_increment = 1'b1; bus.mar_in = 1'b1;
        bus.zlow_in = 1'b1; bus.zhigh_in = 1'b1;
        nxt = T1;
      end
      T1: begin
        bus.zlow_out = 1'b1; bus.pc_in = 1'b1; bus.read = 1'b1; bus.mdr_in = 1'b1;
        if (bus.mem_ack) nxt = T2;
        else if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
          nxt     = IDLE;
          timeout = 1'b1;
        end
      end
      T2: begin
        bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
        nxt = T3;
      end
      T3: begin
        if (!legal) begin
          bus.illegal = 1'b1;
          nxt         = IDLE;
        end else begin
          bus.rout = rb_oh;
          if (cls == CLS_ONE_OP) begin
            bus.op_code = OPC_W'(opc_q);
            bus.zlow_in = 1'b1; bus.zhigh_in = 1'b1;
            nxt = T5;
          end else begin
            bus.y_in = 1'b1;
            nxt = T4;
          end
        end
      end
      T4: begin
        bus.rout    = rc_oh;
        bus.op_code = OPC_W'(opc_q);
        bus.zlow_in = 1'b1; bus.zhigh_in = 1'b1;
        nxt = T5;
      end
      T5: begin
        bus.zlow_out = 1'b1;
        if (cls == CLS_MULDIV) begin
          bus.lo_in = 1'b1;
          nxt = T6;
        end else begin
          bus.rin  = ra_oh;
          bus.done = 1'b1;
          nxt = IDLE;
        end
      end
      T6: begin
        bus.zhigh_out = 1'b1; bus.hi_in = 1'b1; bus.done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Directed-step bench for ctrl_step_sequencer (NUM_REGS=8, MEM_TIMEOUT=4).
module tb_ctrl_step_sequencer;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ctrl_step_sequencer_if #(.DATA_W(32), .NUM_REGS(8), .OPC_W(5)) bus();

  ctrl_step_sequencer #(.DATA_W(32), .NUM_REGS(8), .OPC_W(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  // control vector, MSB first: pc_out pc_inc mar_in zlow_in zhigh_in zlow_out
  // zhigh_out pc_in read mdr_in mdr_out ir_in y_in lo_in hi_in
  localparam logic [14:0] C_0   = 15'h0000;
  localparam logic [14:0] C_T0  = 15'h7C00;
  localparam logic [14:0] C_T1  = 15'h02E0;
  localparam logic [14:0] C_T2  = 15'h0018;
  localparam logic [14:0] C_Y   = 15'h0004;
  localparam logic [14:0] C_Z   = 15'h0C00;
  localparam logic [14:0] C_ZLO = 15'h0200;
  localparam logic [14:0] C_LO  = 15'h0202;
  localparam logic [14:0] C_HI  = 15'h0101;
  // flags: busy done illegal mem_err
  localparam logic [3:0] F_0 = 4'b0000, F_B = 4'b1000, F_DN = 4'b1100;
  localparam logic [3:0] F_IL = 4'b1010, F_ER = 4'b0001;

  localparam logic [31:0] IR_NEG  = 32'h8890_0000;
  localparam logic [31:0] IR_ADD  = 32'h1A9A_0000;
  localparam logic [31:0] IR_MUL  = 32'h7833_8000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;
  localparam logic [31:0] IR_RA15 = 32'h8F90_0000;

  int    vectors = 0;
  int    miscompares = 0;
  string tn = "rst";

  function automatic logic [14:0] ctl_now();
    return {bus.pc_out, bus.pc_increment, bus.mar_in, bus.zlow_in, bus.zhigh_in,
            bus.zlow_out, bus.zhigh_out, bus.pc_in, bus.read, bus.mdr_in,
            bus.mdr_out, bus.ir_in, bus.y_in, bus.lo_in, bus.hi_in};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [14:0] c, input logic [7:0] ri,
                            input logic [7:0] ro, input logic [4:0] op, input logic [3:0] f);
    chk({tn, "/", tag, ".ctl"},   16'(ctl_now()), 16'(c));
    chk({tn, "/", tag, ".rin"},   16'(bus.rin), 16'(ri));
    chk({tn, "/", tag, ".rout"},  16'(bus.rout), 16'(ro));
    chk({tn, "/", tag, ".op"},    16'(bus.op_code), 16'(op));
    chk({tn, "/", tag, ".flags"}, 16'({bus.busy, bus.done, bus.illegal, bus.mem_err}), 16'(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, T0, (waits+1) T1 cycles with ack on the last, ends sampling T2
  task automatic fetch(input logic [31:0] instr, input int waits);
    bus.ir    = instr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_cyc("t0", C_T0, 8'h00, 8'h00, 5'd0, F_B);
    tick();
    for (int i = 0; i <= waits; i++) begin
      bus.mem_ack = (i == waits);
      expect_cyc("t1", C_T1, 8'h00, 8'h00, 5'd0, F_B);
      tick();
    end
    bus.mem_ack = 1'b0;
    expect_cyc("t2", C_T2, 8'h00, 8'h00, 5'd0, F_B);
  endtask

  initial begin
    clr = 1'b0; bus.start = 1'b0; bus.mem_ack = 1'b0; bus.ir = '0;
    #3;
    expect_cyc("async", C_0, 8'h00, 8'h00, 5'd0, F_0);
    #9 clr = 1'b1;
    tick();
    expect_cyc("idle", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "neg";
    fetch(IR_NEG, 0);
    tick(); expect_cyc("t3", C_Z, 8'h00, 8'h04, 5'b10001, F_B);
    tick(); expect_cyc("t5", C_ZLO, 8'h02, 8'h00, 5'd0, F_DN);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "add";
    fetch(IR_ADD, 0);
    tick(); expect_cyc("t3", C_Y, 8'h00, 8'h08, 5'd0, F_B);
    bus.ir = IR_BAD;
    tick(); expect_cyc("t4", C_Z, 8'h00, 8'h10, 5'b00011, F_B);
    tick(); expect_cyc("t5", C_ZLO, 8'h20, 8'h00, 5'd0, F_DN);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "mul";
    fetch(IR_MUL, 0);
    tick(); expect_cyc("t3", C_Y, 8'h00, 8'h40, 5'd0, F_B);
    tick(); expect_cyc("t4", C_Z, 8'h00, 8'h80, 5'b01111, F_B);
    tick(); expect_cyc("t5", C_LO, 8'h00, 8'h00, 5'd0, F_B);
    tick(); expect_cyc("t6", C_HI, 8'h00, 8'h00, 5'd0, F_DN);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "ack4";
    fetch(IR_ADD, 3);
    tick(); expect_cyc("t3", C_Y, 8'h00, 8'h08, 5'd0, F_B);
    tick(); expect_cyc("t4", C_Z, 8'h00, 8'h10, 5'b00011, F_B);
    tick(); expect_cyc("t5", C_ZLO, 8'h20, 8'h00, 5'd0, F_DN);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "tmo";
    bus.ir = IR_ADD; bus.mem_ack = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_cyc("t0", C_T0, 8'h00, 8'h00, 5'd0, F_B);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_cyc("t1", C_T1, 8'h00, 8'h00, 5'd0, F_B);
      tick();
    end
    expect_cyc("err", C_0, 8'h00, 8'h00, 5'd0, F_ER);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "badop";
    fetch(IR_BAD, 0);
    tick(); expect_cyc("t3", C_0, 8'h00, 8'h00, 5'd0, F_IL);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "ra15";
    fetch(IR_RA15, 0);
    tick(); expect_cyc("t3", C_0, 8'h00, 8'h00, 5'd0, F_IL);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "ovl";
    fetch(IR_NEG, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_cyc("t3", C_Z, 8'h00, 8'h04, 5'b10001, F_B);
    tick(); expect_cyc("t5", C_ZLO, 8'h02, 8'h00, 5'd0, F_DN);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);
    tick(); expect_cyc("noq", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "midrst";
    fetch(IR_MUL, 0);
    tick(); tick();
    expect_cyc("t4", C_Z, 8'h00, 8'h80, 5'b01111, F_B);
    #2 clr = 1'b0;
    #1 expect_cyc("async", C_0, 8'h00, 8'h00, 5'd0, F_0);
    tick(); expect_cyc("held", C_0, 8'h00, 8'h00, 5'd0, F_0);
    #2 clr = 1'b1;
    tick(); expect_cyc("rel", C_0, 8'h00, 8'h00, 5'd0, F_0);

    tn = "post";
    fetch(IR_NEG, 0);
    tick(); expect_cyc("t3", C_Z, 8'h00, 8'h04, 5'b10001, F_B);
    tick(); expect_cyc("t5", C_ZLO, 8'h02, 8'h00, 5'd0, F_DN);
    tick(); expect_cyc("end", C_0, 8'h00, 8'h00, 5'd0, F_0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
